// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execution stage of the MIPS-Lite 5-stage pipeline.
// Sits between decode/register-read and the memory stage. Computes the ALU
// result, resolves BEQ and JR, computes the branch target, and runs an
// iterative shift-add multiplier that holds off decode while it works.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   decode-side handshake (in_ready is combinational)
//   rs1_val, rs2_val, imm operands (imm already sign-extended)
//   pc_plus4              PC+4 of the instruction
//   aluop, use_imm        operation select, operand-2 select
//   flush                 kill the held result and the incoming instruction
//   out_valid / out_ready memory-side handshake
//   alu_out, wr_data      ALU/MUL result, captured store data
//   new_addr, branch_taken redirect target and redirect request
//   ovf                   signed ADD/SUB overflow or branch-target wrap
//   busy                  multiplier iterating
module ex_stage_pipe #(
    parameter int DATA               = 32,
    parameter int ADDRESSWIDTH       = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA-1:0]         rs1_val,
    input  logic [DATA-1:0]         rs2_val,
    input  logic [DATA-1:0]         imm,
    input  logic [ADDRESSWIDTH-1:0] pc_plus4,
    input  logic [3:0]              aluop,
    input  logic                    use_imm,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA-1:0]         alu_out,
    output logic [DATA-1:0]         wr_data,
    output logic [ADDRESSWIDTH-1:0] new_addr,
    output logic                    branch_taken,
    output logic                    ovf,
    output logic                    busy
);

    localparam int MUL_STEPS = DATA / MUL_BITS_PER_CYCLE;
    localparam int CNT_W     = $clog2(MUL_STEPS);
    // Branch target is formed at full precision so wrap can be detected.
    localparam int TW        = DATA + 3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_JR  = 4'd8;

    typedef enum logic [1:0] {s_empty, s_full, s_mul} state_t;

    state_t                  state;
    logic                    accept;
    logic                    is_mul;

    logic [DATA-1:0]         op2;
    logic [DATA-1:0]         sum;
    logic [DATA-1:0]         diff;
    logic                    add_ovf;
    logic                    sub_ovf;
    logic signed [TW-1:0]    tgt;
    logic [TW-ADDRESSWIDTH:0] tgt_top;
    logic                    tgt_ovf;

    logic [DATA-1:0]         res_alu;
    logic [ADDRESSWIDTH-1:0] res_addr;
    logic                    res_br;
    logic                    res_ovf;

    logic [DATA-1:0]         mul_acc;
    logic [DATA-1:0]         mul_mcand;
    logic [DATA-1:0]         mul_mplier;
    logic [CNT_W-1:0]        mul_cnt;
    logic [DATA-1:0]         mul_partial;
    logic [DATA-1:0]         mul_acc_next;

    assign in_ready  = (state == s_empty) | ((state == s_full) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state == s_full);
    assign busy      = (state == s_mul);
    assign is_mul    = (aluop == OP_MUL);

    assign op2  = use_imm ? imm : rs2_val;
    assign sum  = rs1_val + op2;
    assign diff = rs1_val - op2;

    // Overflow: result sign differs from what the operand signs allow.
    assign add_ovf = (rs1_val[DATA-1] == op2[DATA-1]) && (sum[DATA-1]  != rs1_val[DATA-1]);
    assign sub_ovf = (rs1_val[DATA-1] != op2[DATA-1]) && (diff[DATA-1] != rs1_val[DATA-1]);

    // Target wraps when the upper bits are not a pure sign extension.
    assign tgt     = TW'(signed'(pc_plus4)) + (TW'(signed'(imm)) <<< 2);
    assign tgt_top = tgt[TW-1:ADDRESSWIDTH-1];
    assign tgt_ovf = (|tgt_top) & ~(&tgt_top);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        res_alu  = sum;
        res_addr = '0;
        res_br   = 1'b0;
        res_ovf  = 1'b0;
        case (aluop)
            OP_SUB: begin
                res_alu = diff;
                res_ovf = sub_ovf;
            end
            OP_AND: res_alu = rs1_val & op2;
            OP_OR:  res_alu = rs1_val | op2;
            OP_XOR: res_alu = rs1_val ^ op2;
            OP_SLT: begin
                res_alu    = '0;
                res_alu[0] = $signed(rs1_val) < $signed(op2);
            end
            OP_BEQ: begin
                res_alu  = rs1_val - rs2_val;
                res_br   = (rs1_val == rs2_val);
                res_addr = tgt[ADDRESSWIDTH-1:0];
                res_ovf  = tgt_ovf;
            end
            OP_JR: begin
                res_alu  = DATA'(pc_plus4);
                res_br   = 1'b1;
                res_addr = rs1_val[ADDRESSWIDTH-1:0];
            end
            default: res_ovf = add_ovf; // ADD and the unassigned codes
        endcase
    end

    // One shift-add step: add the multiplicand for each multiplier bit retired.
    always_comb begin
        mul_partial = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mul_mplier[j]) mul_partial = mul_partial + (mul_mcand << j);
        end
        mul_acc_next = mul_acc + mul_partial;
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= s_empty;
            alu_out      <= '0;
            wr_data      <= '0;
            new_addr     <= '0;
            branch_taken <= 1'b0;
            ovf          <= 1'b0;
            mul_acc      <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            mul_cnt      <= '0;
        end else if (flush) begin
            state <= s_empty;
        end else begin
            case (state)
                s_mul: begin
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << MUL_BITS_PER_CYCLE;
                    mul_mplier <= mul_mplier >> MUL_BITS_PER_CYCLE;
                    if (mul_cnt == '0) begin
                        alu_out <= mul_acc_next;
                        state   <= s_full;
                    end else begin
                        mul_cnt <= mul_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    // accept implies out_ready when FULL, so a reload needs no bubble.
                    if (accept) begin
                        wr_data <= rs2_val;
                        if (is_mul) begin
                            mul_acc      <= '0;
                            mul_mcand    <= rs1_val;
                            mul_mplier   <= op2;
                            mul_cnt      <= CNT_W'(MUL_STEPS - 1);
                            branch_taken <= 1'b0;
                            new_addr     <= '0;
                            ovf          <= 1'b0;
                            state        <= s_mul;
                        end else begin
                            alu_out      <= res_alu;
                            new_addr     <= res_addr;
                            branch_taken <= res_br;
                            ovf          <= res_ovf;
                            state        <= s_full;
                        end
                    end else if ((state == s_full) && out_ready) begin
                        state <= s_empty;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;

    localparam logic [63:0] SMAX = 64'h0000_0000_7fff_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_val, rs2_val, imm, pc_plus4;
    logic [3:0]  aluop;
    logic        use_imm;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out, wr_data, new_addr;
    logic        branch_taken, ovf, busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wr;
        logic [31:0] addr;
        logic        br;
        logic        ovf;
    } res_t;

    ex_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc_plus4(pc_plus4),
        .aluop(aluop), .use_imm(use_imm), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .wr_data(wr_data),
        .new_addr(new_addr), .branch_taken(branch_taken), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // True when a mathematical integer does not fit a 32-bit signed value.
    function automatic logic out_of_range(input longint r);
        return (r > longint'(SMAX)) || (r < -longint'(SMAX) - 64'sd1);
    endfunction

    // Reference model: each instruction's expected outputs from plain arithmetic.
    function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im,
                                   input logic ui, input logic [31:0] pc);
        res_t        e;
        logic [31:0] o2;
        logic signed [31:0] a_s, o2_s, im_s, pc_s;
        longint      r;
        logic [63:0] p;
        o2   = ui ? im : b;
        a_s  = a;  o2_s = o2;  im_s = im;  pc_s = pc;
        e.wr = b;  e.addr = 32'd0;  e.br = 1'b0;  e.ovf = 1'b0;
        case (op)
            4'd1: begin
                r = longint'(a_s) - longint'(o2_s);
                e.alu = r[31:0];
                e.ovf = out_of_range(r);
            end
            4'd2: e.alu = a & o2;
            4'd3: e.alu = a | o2;
            4'd4: e.alu = a ^ o2;
            4'd5: e.alu = (a_s < o2_s) ? 32'd1 : 32'd0;
            4'd6: begin
                p = {32'd0, a} * {32'd0, o2};
                e.alu = p[31:0];
            end
            4'd7: begin
                e.alu  = a - b;
                e.br   = (a == b);
                r      = longint'(pc_s) + longint'(im_s) * 4;
                e.addr = r[31:0];
                e.ovf  = out_of_range(r);
            end
            4'd8: begin
                e.alu  = pc;
                e.br   = 1'b1;
                e.addr = a;
            end
            default: begin
                r = longint'(a_s) + longint'(o2_s);
                e.alu = r[31:0];
                e.ovf = out_of_range(r);
            end
        endcase
        return e;
    endfunction

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic ui, input logic [31:0] pc);
        aluop = op; rs1_val = a; rs2_val = b; imm = im; use_imm = ui; pc_plus4 = pc;
    endtask

    // Present an instruction, wait (bounded) for in_ready, return just after the accept edge.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic ui,
                         input logic [31:0] pc);
        int n;
        set_in(op, a, b, im, ui, pc);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        if (!in_ready) chk({tag, ".accept_timeout"}, {63'd0, in_ready}, 64'd1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick;
            n++;
        end
        chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic expect_fields(input string tag, input res_t e);
        chk({tag, ".alu"},  {32'd0, alu_out},      {32'd0, e.alu});
        chk({tag, ".wr"},   {32'd0, wr_data},      {32'd0, e.wr});
        chk({tag, ".addr"}, {32'd0, new_addr},     {32'd0, e.addr});
        chk({tag, ".br"},   {63'd0, branch_taken}, {63'd0, e.br});
        chk({tag, ".ovf"},  {63'd0, ovf},          {63'd0, e.ovf});
    endtask

    // Count cycles with out_valid high over a window; expected none.
    task automatic watch_silent(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            if (out_valid) seen++;
            tick;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        res_t        e;
        int          busy_cnt;
        int          edges;
        logic [3:0]  op;
        logic [31:0] a, b, im, pc;
        logic        ui;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick; tick;
        reset = 1'b0;
        #1;
        chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset.in_ready",  {63'd0, in_ready},  64'd1);
        chk("reset.busy",      {63'd0, busy},      64'd0);
        e = '{alu: 32'd0, wr: 32'd0, addr: 32'd0, br: 1'b0, ovf: 1'b0};
        expect_fields("reset", e);

        // Reset in the middle of a multiply aborts it with no output.
        issue("rstmul", 4'd6, 32'd7, 32'd6, 32'd0, 1'b0, 32'd0);
        chk("rstmul.busy_started", {63'd0, busy}, 64'd1);
        repeat (5) tick;
        reset = 1'b1;
        #1;
        chk("rstmul.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmul.busy",      {63'd0, busy},      64'd0);
        chk("rstmul.in_ready",  {63'd0, in_ready},  64'd1);
        tick;
        reset = 1'b0;
        watch_silent("rstmul.no_output", 40);

        // ADD overflow, then back-to-back SUB without a bubble.
        out_ready = 1'b1;
        issue("add", 4'd0, 32'h7fff_ffff, 32'd1, 32'd0, 1'b0, 32'd0);
        chk("add.out_valid", {63'd0, out_valid}, 64'd1);
        chk("add.alu", {32'd0, alu_out}, 64'h8000_0000);
        chk("add.ovf", {63'd0, ovf}, 64'd1);
        set_in(4'd1, 32'd5, 32'd9, 32'd0, 1'b0, 32'd0);
        in_valid = 1'b1;
        #1;
        chk("b2b.in_ready", {63'd0, in_ready}, 64'd1);
        tick;
        in_valid = 1'b0;
        chk("sub.out_valid", {63'd0, out_valid}, 64'd1);
        chk("sub.alu", {32'd0, alu_out}, 64'hffff_fffc);
        chk("sub.ovf", {63'd0, ovf}, 64'd0);
        tick;
        chk("sub.consumed", {63'd0, out_valid}, 64'd0);

        // BEQ taken and not taken.
        issue("beq_t", 4'd7, 32'h10, 32'h10, 32'hffff_fffe, 1'b0, 32'h100);
        chk("beq_t.br",   {63'd0, branch_taken}, 64'd1);
        chk("beq_t.addr", {32'd0, new_addr},     64'hf8);
        tick;
        issue("beq_n", 4'd7, 32'h10, 32'h11, 32'hffff_fffe, 1'b0, 32'h100);
        chk("beq_n.br",   {63'd0, branch_taken}, 64'd0);
        chk("beq_n.addr", {32'd0, new_addr},     64'hf8);
        tick;

        // Multiply: 32 busy cycles, result 33 edges after accept; then a held result.
        out_ready = 1'b0;
        issue("mul", 4'd6, 32'hffff_ffff, 32'd3, 32'd0, 1'b0, 32'd0);
        busy_cnt = 0;
        edges    = 1;
        while (!out_valid && edges < 60) begin
            if (busy && !in_ready) busy_cnt++;
            tick;
            edges++;
        end
        chk("mul.busy_cycles", 64'(busy_cnt), 64'd32);
        chk("mul.latency",     64'(edges),    64'd33);
        chk("mul.out_valid",   {63'd0, out_valid}, 64'd1);
        chk("mul.alu",         {32'd0, alu_out},   64'hffff_fffd);
        chk("mul.busy_done",   {63'd0, busy},      64'd0);

        set_in(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold.in_ready",  {63'd0, in_ready},  64'd0);
            chk("hold.out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold.alu",       {32'd0, alu_out},   64'hffff_fffd);
            chk("hold.wr",        {32'd0, wr_data},   64'd3);
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("hold.not_accepted", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;

        // Flush during a multiply.
        issue("flmul", 4'd6, 32'd5, 32'd5, 32'd0, 1'b0, 32'd0);
        repeat (3) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flmul.out_valid", {63'd0, out_valid}, 64'd0);
        chk("flmul.busy",      {63'd0, busy},      64'd0);
        chk("flmul.in_ready",  {63'd0, in_ready},  64'd1);
        watch_silent("flmul.no_output", 40);

        // Flush while FULL with a would-be-accepted instruction present.
        issue("flfull", 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0);
        chk("flfull.loaded", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        set_in(4'd4, 32'hdead_beef, 32'h1234_5678, 32'd0, 1'b0, 32'd0);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flfull.out_valid", {63'd0, out_valid}, 64'd0);
        chk("flfull.in_ready",  {63'd0, in_ready},  64'd1);
        watch_silent("flfull.no_output", 5);
        out_ready = 1'b0;

        // Randomized transactions against the reference model.
        for (int t = 0; t < 40; t++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) op = 4'd6;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
            ui = 1'($urandom_range(0, 1));
            pc = $urandom;
            e  = model(op, a, b, im, ui, pc);
            issue("rnd", op, a, b, im, ui, pc);
            wait_valid("rnd", 60);
            expect_fields($sformatf("rnd%0d_op%0d", t, op), e);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                tick;
                chk("rnd.stall_alu", {32'd0, alu_out}, {32'd0, e.alu});
            end
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            chk("rnd.consumed", {63'd0, out_valid}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Parametrised, registered execution stage for the MIPS-Lite 5-stage pipeline. It sits between the decode/register-read stage and the memory stage. It performs the ALU operation, resolves branches and jump-register, and computes the branch target. Results are held in an output register with valid/ready handshakes on both sides, so the stage can stall and flush. It adds an iterative multi-cycle multiplier that back-pressures decode while it runs.

Parameters:
DATA, 32, datapath width in bits (>=8)
ADDRESSWIDTH, 32, PC/address width in bits (<=DATA)
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; must divide DATA; 1, 2 or 4

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
rs1_val  input  DATA  source operand 1
rs2_val  input  DATA  source operand 2 / store data
imm  input  DATA  sign-extended immediate
pc_plus4  input  ADDRESSWIDTH  PC+4 of the instruction
aluop  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT(signed), 6 MUL, 7 BEQ, 8 JR; 9-15 treated as ADD
use_imm  input  1  ALU operand 2 = imm instead of rs2_val
flush  input  1  kill the in-flight result and any incoming instruction
out_valid  output  1  result register holds a valid result
out_ready  input  1  memory stage consumes the result
alu_out  output  DATA  ALU/MUL result
wr_data  output  DATA  registered rs2_val (store data)
new_addr  output  ADDRESSWIDTH  redirect target (branch target or rs1_val)
branch_taken  output  1  redirect required; qualified by out_valid
ovf  output  1  signed ADD/SUB overflow, or branch-target wrap
busy  output  1  multiplier iterating

Behaviour:
- Reset: state EMPTY; out_valid=0, busy=0, in_ready=1 (combinational from EMPTY); alu_out, wr_data, new_addr, branch_taken, ovf all 0; multiplier accumulator 0. Reset mid-multiply aborts with no output.
- States: EMPTY, FULL, MUL.
- Handshake: accept = in_valid & in_ready & ~flush. in_ready = EMPTY | (FULL & out_ready). in_ready=0 in MUL. Output changes only on accept or on flush/consume. out_valid/out fields stay stable while out_valid & ~out_ready.
- EMPTY: on accept of a non-MUL op, load the result register next edge and go to FULL (latency 1). On accept of MUL, go to MUL.
- FULL: out_ready & ~accept -> EMPTY. out_ready & accept -> reload the register (back-to-back, no bubble), or go to MUL if the accepted op is MUL (out_valid drops). ~out_ready -> hold.
- MUL: shift-add over DATA/MUL_BITS_PER_CYCLE cycles, then load alu_out with the low DATA bits of the product and go to FULL. Total latency from accept is DATA/MUL_BITS_PER_CYCLE+1 edges. busy=1 only in MUL.
- flush: highest priority. Next edge -> EMPTY, out_valid=0, multiplier aborted; the same-cycle input is discarded.
- ADD/SUB: modular DATA-bit arithmetic. ovf = signed overflow.
- SLT: alu_out = {0..,1} if signed op1<op2, else 0.
- BEQ: branch_taken = (rs1_val==rs2_val). new_addr = pc_plus4 + (imm<<2), signed, truncated to ADDRESSWIDTH. ovf=1 if the signed sum wraps. alu_out = rs1_val-rs2_val.
- JR: branch_taken=1, new_addr = rs1_val[ADDRESSWIDTH-1:0], alu_out = pc_plus4 zero-extended.
- Non-branch ops: branch_taken=0, new_addr=0. ovf=0 for ops other than ADD, SUB and BEQ.
- wr_data always = rs2_val captured at accept.

Test Plan:
- Reset mid-MUL (rs1=7, rs2=6, reset after 5 cycles) -> out_valid=0, busy=0, in_ready=1 immediately; no output after release.
- ADD 0x7FFFFFFF+1, out_ready=1 -> one edge later out_valid=1, alu_out=0x80000000, ovf=1; then back-to-back SUB 5-9 -> alu_out=0xFFFFFFFC, ovf=0, no bubble.
- BEQ rs1=rs2=0x10, pc_plus4=0x100, imm=0xFFFFFFFE -> branch_taken=1, new_addr=0xF8. Repeat with rs2=0x11 -> branch_taken=0.
- MUL 0xFFFFFFFF*3 (DATA=32, bits/cycle=1) -> in_ready=0, busy=1 for 32 cycles; alu_out=0xFFFFFFFD 33 edges after accept.
- out_ready=0 for 4 cycles with a result held -> fields stable, in_ready=0, a new in_valid is not accepted.
- flush during MUL and also flush during FULL with in_valid=1 -> next cycle out_valid=0, state EMPTY, incoming instruction never appears.
